// File: rtl/game_flow_controller.sv
// game_flow_controller: top-level game-flow FSM for the VGA game pipeline.
// Sequences START -> PLAY -> DYING/CLEAR holds -> WIN/LOSE, tracks lives and
// level, pulses respawn, and muxes four pre-rendered pixel sources onto
// registered RGB outputs. All outputs are registered.
// Optional feature: define GAME_PAUSE_KEY_EN to enable the 'P' (0x13) pause key.
module game_flow_controller #(
    parameter int COLOR_W    = 8,
    parameter int N_LIVES    = 3,
    parameter int N_LEVELS   = 4,
    parameter int TICK_DIV   = 1000,
    parameter int HOLD_TICKS = 1023
) (
    input  logic                                            VGA_Clk,
    input  logic                                            Reset_n,
    input  logic [7:0]                                      keycode,
    input  logic                                            lost_evt,
    input  logic                                            win_evt,
    input  logic                                            blank,
    input  logic [3*COLOR_W-1:0]                            pix_start,
    input  logic [3*COLOR_W-1:0]                            pix_game,
    input  logic [3*COLOR_W-1:0]                            pix_win,
    input  logic [3*COLOR_W-1:0]                            pix_lose,
    output logic [2:0]                                      State_out,
    output logic                                            moving,
    output logic [$clog2(N_LIVES+1)-1:0]                    lives,
    output logic [((N_LEVELS > 1) ? $clog2(N_LEVELS) : 1)-1:0] level,
    output logic                                            respawn,
    output logic [COLOR_W-1:0]                              Red,
    output logic [COLOR_W-1:0]                              Green,
    output logic [COLOR_W-1:0]                              Blue
);

    localparam int LIVES_W = $clog2(N_LIVES + 1);
    localparam int LEVEL_W = (N_LEVELS > 1) ? $clog2(N_LEVELS) : 1;
    localparam int DIV_W   = $clog2(TICK_DIV);
    localparam int HOLD_W  = $clog2(HOLD_TICKS + 1);
    localparam int PIX_W   = 3 * COLOR_W;

    typedef enum logic [2:0] {
        ST_START  = 3'd0,
        ST_PLAY   = 3'd1,
        ST_DYING  = 3'd2,
        ST_WIN    = 3'd3,
        ST_LOSE   = 3'd4,
        ST_CLEAR  = 3'd5,
        ST_PAUSED = 3'd6
    } state_t;

    state_t               state_q, state_d;
    logic                 moving_q, moving_d;
    logic                 respawn_q, respawn_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic [LEVEL_W-1:0]   level_q, level_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [PIX_W-1:0]     rgb_q, rgb_d;

    logic tick;
    logic hold_done;
    logic start_key;
    logic in_hold;
    logic pause_rise;

    assign tick      = (div_q == DIV_W'(TICK_DIV - 1));
    assign hold_done = tick && (hold_q == HOLD_W'(1));
    assign in_hold   = (state_q == ST_DYING) || (state_q == ST_CLEAR);
    assign start_key = (keycode == 8'h04) || (keycode == 8'h07) || (keycode == 8'h16) ||
                       (keycode == 8'h1A) || (keycode == 8'h28);

`ifdef GAME_PAUSE_KEY_EN
    logic [7:0] key_prev_q, key_prev_d;

    assign key_prev_d = keycode;
    assign pause_rise = (keycode == 8'h13) && (key_prev_q != 8'h13);

    // Previous keycode, so a held 'P' toggles pause only once
    always_ff @(posedge VGA_Clk or negedge Reset_n) begin
        if (!Reset_n) key_prev_q <= 8'h00;
        else          key_prev_q <= key_prev_d;
    end
`else
    assign pause_rise = 1'b0;
`endif

    // State and datapath registers; reset discards any hold in progress
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge VGA_Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= ST_START;
            moving_q  <= 1'b0;
            respawn_q <= 1'b0;
            lives_q   <= LIVES_W'(N_LIVES);
            level_q   <= '0;
            div_q     <= '0;
            hold_q    <= '0;
            rgb_q     <= '0;
        end else begin
            state_q   <= state_d;
            moving_q  <= moving_d;
            respawn_q <= respawn_d;
            lives_q   <= lives_d;
            level_q   <= level_d;
            div_q     <= div_d;
            hold_q    <= hold_d;
            rgb_q     <= rgb_d;
        end
    end

    // Next-state logic; engine events only matter in PLAY, lost_evt has priority
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_START: if (start_key) state_d = ST_PLAY;
            ST_PLAY: begin
                if (lost_evt)        state_d = ST_DYING;
                else if (win_evt)    state_d = ST_CLEAR;
                else if (pause_rise) state_d = ST_PAUSED;
            end
            ST_DYING: begin
                if (hold_done) state_d = (lives_q == LIVES_W'(1)) ? ST_LOSE : ST_PLAY;
            end
            ST_CLEAR: begin
                if (hold_done) state_d = (level_q == LEVEL_W'(N_LEVELS - 1)) ? ST_WIN : ST_PLAY;
            end
            ST_PAUSED: if (pause_rise) state_d = ST_PLAY;
            default: state_d = state_q;
        endcase
    end

    // Outputs and counters derived from the current and next state
    always_comb begin
        moving_d  = (state_d == ST_PLAY);
        respawn_d = in_hold && (state_d == ST_PLAY);
        lives_d   = lives_q;
        level_d   = level_q;
        hold_d    = hold_q;
        div_d     = tick ? '0 : div_q + DIV_W'(1);
        rgb_d     = '0;

        if (state_q == ST_DYING && hold_done) lives_d = lives_q - LIVES_W'(1);
        if (state_q == ST_CLEAR && hold_done && state_d == ST_PLAY) level_d = level_q + LEVEL_W'(1);

        if (state_q == ST_PLAY && (state_d == ST_DYING || state_d == ST_CLEAR))
            hold_d = HOLD_W'(HOLD_TICKS);
        else if (in_hold && tick)
            hold_d = hold_q - HOLD_W'(1);

        if (blank) begin
            case (state_q)
                ST_START: rgb_d = pix_start;
                ST_WIN:   rgb_d = pix_win;
                ST_LOSE:  rgb_d = pix_lose;
                default:  rgb_d = pix_game;
            endcase
        end
    end

    assign State_out = state_q;
    assign moving    = moving_q;
    assign respawn   = respawn_q;
    assign lives     = lives_q;
    assign level     = level_q;
    assign Red       = rgb_q[PIX_W-1 -: COLOR_W];
    assign Green     = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign Blue      = rgb_q[COLOR_W-1:0];

endmodule

// File: tb/tb_game_flow_controller.sv
// tb_game_flow_controller: directed scoreboard bench for game_flow_controller
// with TICK_DIV=4, HOLD_TICKS=2, N_LIVES=3, N_LEVELS=2.
module tb_game_flow_controller;

    localparam int TD = 4;
    localparam logic [23:0] PS = 24'h111111;
    localparam logic [23:0] PG = 24'hFFFFFF;
    localparam logic [23:0] PW = 24'h00AA00;
    localparam logic [23:0] PL = 24'hAA0000;

    logic        VGA_Clk = 1'b0;
    logic        Reset_n;
    logic [7:0]  keycode;
    logic        lost_evt, win_evt, blank;
    logic [23:0] pix_start, pix_game, pix_win, pix_lose;
    logic [2:0]  State_out;
    logic        moving, respawn;
    logic [1:0]  lives;
    logic [0:0]  level;
    logic [7:0]  Red, Green, Blue;

    int n_assert = 0;
    int n_fail   = 0;
    int edge_cnt;

    typedef struct {
        string tag;
        int    st;
        int    mv;
        int    lv;
        int    lvl;
        int    rsp;
        logic [23:0] rgb;
    } exp_t;

    exp_t sb_q[$];

    game_flow_controller #(
        .COLOR_W(8), .N_LIVES(3), .N_LEVELS(2), .TICK_DIV(TD), .HOLD_TICKS(2)
    ) dut (
        .VGA_Clk(VGA_Clk), .Reset_n(Reset_n), .keycode(keycode),
        .lost_evt(lost_evt), .win_evt(win_evt), .blank(blank),
        .pix_start(pix_start), .pix_game(pix_game), .pix_win(pix_win), .pix_lose(pix_lose),
        .State_out(State_out), .moving(moving), .lives(lives), .level(level),
        .respawn(respawn), .Red(Red), .Green(Green), .Blue(Blue)
    );

    always #5 VGA_Clk = ~VGA_Clk;

    // Divider model: edges since reset release; the next edge is a tick edge when edge_cnt%TD == TD-1
    always @(posedge VGA_Clk or negedge Reset_n) begin
        if (!Reset_n) edge_cnt <= 0;
        else          edge_cnt <= edge_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input int st, input int mv, input int lv,
                        input int lvl, input int rsp, input logic [23:0] rgb);
        exp_t e;
        e.tag = tag; e.st = st; e.mv = mv; e.lv = lv; e.lvl = lvl; e.rsp = rsp; e.rgb = rgb;
        sb_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            cmp("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        cmp({e.tag, ".state"},   32'(State_out), 32'(e.st));
        cmp({e.tag, ".moving"},  32'(moving),    32'(e.mv));
        cmp({e.tag, ".lives"},   32'(lives),     32'(e.lv));
        cmp({e.tag, ".level"},   32'(level),     32'(e.lvl));
        cmp({e.tag, ".respawn"}, 32'(respawn),   32'(e.rsp));
        cmp({e.tag, ".rgb"},     32'({Red, Green, Blue}), 32'(e.rgb));
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, then compare after the edge
    // NOTE: bench inputs are driven with blocking assignments away from the clock edge.
    task automatic step(input logic [7:0] key, input logic lost, input logic win, input logic blk,
                        input string tag, input int st, input int mv, input int lv,
                        input int lvl, input int rsp, input logic [23:0] rgb);
        keycode = key; lost_evt = lost; win_evt = win; blank = blk;
        push(tag, st, mv, lv, lvl, rsp, rgb);
        @(posedge VGA_Clk);
        #1;
        pop_check();
        keycode = 8'h00; lost_evt = 1'b0; win_evt = 1'b0; blank = 1'b1;
    endtask

    // Idle until the coming edge is a tick edge, so a hold entered there lasts exactly 8 cycles
    task automatic align_tick();
        keycode = 8'h00; lost_evt = 1'b0; win_evt = 1'b0; blank = 1'b1;
        for (int i = 0; i < TD && (edge_cnt % TD) != TD - 1; i++) begin
            @(posedge VGA_Clk);
            #1;
        end
    endtask

    // Asynchronous reset between edges; outputs must clear before any edge
    task automatic do_reset(input string tag);
        Reset_n = 1'b0;
        #1;
        push(tag, 0, 0, 3, 0, 0, 24'h0);
        pop_check();
        @(negedge VGA_Clk);
        Reset_n = 1'b1;
    endtask

    // Hold phase: 7 cycles in hold_st, then the exit edge
    task automatic run_hold(input string tag, input int hold_st, input int lv, input int lvl,
                            input int x_st, input int x_mv, input int x_lv, input int x_lvl,
                            input int x_rsp, input logic inject);
        for (int i = 1; i <= 7; i++)
            step(8'h00, inject && (i == 3), inject && (i == 5), 1'b1,
                 {tag, "_hold"}, hold_st, 0, lv, lvl, 0, PG);
        step(8'h00, 1'b0, 1'b0, 1'b1, {tag, "_exit"}, x_st, x_mv, x_lv, x_lvl, x_rsp, PG);
    endtask

    initial begin
        Reset_n = 1'b0;
        keycode = 8'h00; lost_evt = 1'b0; win_evt = 1'b0; blank = 1'b1;
        pix_start = PS; pix_game = PG; pix_win = PW; pix_lose = PL;
        #12;
        push("reset", 0, 0, 3, 0, 0, 24'h0);
        pop_check();
        @(negedge VGA_Clk);
        Reset_n = 1'b1;

        // START: events and non-start keys ignored, then 0x1A starts play
        step(8'h00, 1'b1, 1'b1, 1'b1, "start_evt_ign", 0, 0, 3, 0, 0, PS);
        step(8'h13, 1'b0, 1'b0, 1'b1, "start_p_ign",   0, 0, 3, 0, 0, PS);
        step(8'h1A, 1'b0, 1'b0, 1'b1, "start_key",     1, 1, 3, 0, 0, PS);
        step(8'h00, 1'b0, 1'b0, 1'b1, "play_pix",      1, 1, 3, 0, 0, PG);

        // Blanking forces black one cycle later
        step(8'h00, 1'b0, 1'b0, 1'b0, "blank0", 1, 1, 3, 0, 0, 24'h0);
        step(8'h00, 1'b0, 1'b0, 1'b1, "blank1", 1, 1, 3, 0, 0, PG);

`ifdef GAME_PAUSE_KEY_EN
        step(8'h13, 1'b0, 1'b0, 1'b1, "pause_on", 6, 0, 3, 0, 0, PG);
        for (int i = 0; i < 4; i++)
            step(8'h13, 1'b0, 1'b0, 1'b1, "pause_held", 6, 0, 3, 0, 0, PG);
        step(8'h00, 1'b1, 1'b1, 1'b1, "pause_evt_ign", 6, 0, 3, 0, 0, PG);
        step(8'h00, 1'b0, 1'b0, 1'b1, "pause_idle",    6, 0, 3, 0, 0, PG);
        step(8'h13, 1'b0, 1'b0, 1'b1, "pause_off",     1, 1, 3, 0, 0, PG);
        step(8'h13, 1'b0, 1'b0, 1'b1, "pause_off_held", 1, 1, 3, 0, 0, PG);
`else
        for (int i = 0; i < 5; i++)
            step(8'h13, 1'b0, 1'b0, 1'b1, "p_key_ign", 1, 1, 3, 0, 0, PG);
`endif

        // Three deaths: 8-cycle holds, respawn pulses, then LOSE
        align_tick();
        step(8'h00, 1'b1, 1'b0, 1'b1, "die1_enter", 2, 0, 3, 0, 0, PG);
        run_hold("die1", 2, 3, 0, 1, 1, 2, 0, 1, 1'b0);
        step(8'h00, 1'b0, 1'b0, 1'b1, "die1_rsp_end", 1, 1, 2, 0, 0, PG);

        align_tick();
        step(8'h00, 1'b1, 1'b0, 1'b1, "die2_enter", 2, 0, 2, 0, 0, PG);
        run_hold("die2", 2, 2, 0, 1, 1, 1, 0, 1, 1'b1);
        step(8'h00, 1'b0, 1'b0, 1'b1, "die2_rsp_end", 1, 1, 1, 0, 0, PG);

        align_tick();
        step(8'h00, 1'b1, 1'b0, 1'b1, "die3_enter", 2, 0, 1, 0, 0, PG);
        run_hold("die3", 2, 1, 0, 4, 0, 0, 0, 0, 1'b0);
        step(8'h1A, 1'b0, 1'b1, 1'b1, "lose_frozen", 4, 0, 0, 0, 0, PL);
        step(8'h00, 1'b1, 1'b0, 1'b1, "lose_evt_ign", 4, 0, 0, 0, 0, PL);

        // Level progression to WIN, with simultaneous events resolving to DYING
        do_reset("reset2");
        step(8'h28, 1'b0, 1'b0, 1'b1, "start2", 1, 1, 3, 0, 0, PS);
        align_tick();
        step(8'h00, 1'b0, 1'b1, 1'b1, "clr1_enter", 5, 0, 3, 0, 0, PG);
        run_hold("clr1", 5, 3, 0, 1, 1, 3, 1, 1, 1'b0);
        step(8'h00, 1'b0, 1'b0, 1'b1, "clr1_rsp_end", 1, 1, 3, 1, 0, PG);

        align_tick();
        step(8'h00, 1'b1, 1'b1, 1'b1, "both_evt", 2, 0, 3, 1, 0, PG);
        run_hold("both", 2, 3, 1, 1, 1, 2, 1, 1, 1'b0);

        align_tick();
        step(8'h00, 1'b0, 1'b1, 1'b1, "clr2_enter", 5, 0, 2, 1, 0, PG);
        run_hold("clr2", 5, 2, 1, 3, 0, 2, 1, 0, 1'b0);
        step(8'h04, 1'b1, 1'b1, 1'b1, "win_frozen", 3, 0, 2, 1, 0, PW);

        // Reset in the middle of a hold: no respawn afterwards
        do_reset("reset3");
        step(8'h07, 1'b0, 1'b0, 1'b1, "start3", 1, 1, 3, 0, 0, PS);
        align_tick();
        step(8'h00, 1'b1, 1'b0, 1'b1, "die4_enter", 2, 0, 3, 0, 0, PG);
        step(8'h00, 1'b0, 1'b0, 1'b1, "die4_hold",  2, 0, 3, 0, 0, PG);
        step(8'h00, 1'b0, 1'b0, 1'b1, "die4_hold",  2, 0, 3, 0, 0, PG);
        do_reset("reset_mid_hold");
        for (int i = 0; i < 10; i++)
            step(8'h00, 1'b0, 1'b0, 1'b1, "post_reset", 0, 0, 3, 0, 0, PS);

        if (sb_q.size() != 0) cmp("scoreboard_leftover", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
